// File: rtl/wb_pkg.sv
// Shared constants, cause codes and trap FSM encoding for the writeback/commit stage.
package wb_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  // Exception codes, listed in descending priority after interrupts.
  localparam logic [3:0] CAUSE_IAF     = 4'd1;
  localparam logic [3:0] CAUSE_II      = 4'd2;
  localparam logic [3:0] CAUSE_IAM     = 4'd0;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
  localparam logic [3:0] CAUSE_SAM     = 4'd6;
  localparam logic [3:0] CAUSE_LAM     = 4'd4;
  localparam logic [3:0] CAUSE_SAF     = 4'd7;
  localparam logic [3:0] CAUSE_LAF     = 4'd5;
  localparam logic [3:0] CAUSE_IRQ_EXT = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_TMR = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EPC,
    S_CAUSE,
    S_TVAL,
    S_REDIRECT
  } trap_state_e;

  // Exceptions whose MTVAL carries the faulting address.
  function automatic logic tval_is_addr(input logic [3:0] cause);
    return (cause == CAUSE_IAM) || (cause == CAUSE_IAF) || (cause == CAUSE_LAM) ||
           (cause == CAUSE_LAF) || (cause == CAUSE_SAM) || (cause == CAUSE_SAF);
  endfunction

endpackage

// File: rtl/wb_trap_commit_prio.sv
// Combinational trap priority encoder: interrupts first, then the fixed exception order.
module trap_prio_enc
  import wb_pkg::*;
(
  input  logic       irq_ext,
  input  logic       irq_timer,
  input  logic       iaf,
  input  logic       ii,
  input  logic       iam,
  input  logic       ecall,
  input  logic       priv_m,
  input  logic       sam,
  input  logic       lam,
  input  logic       saf,
  input  logic       laf,
  output logic       take,
  output logic       irq,
  output logic [3:0] cause
);

  always_comb begin
    take  = 1'b1;
    irq   = 1'b0;
    cause = 4'd0;
    if (irq_ext) begin
      irq   = 1'b1;
      cause = CAUSE_IRQ_EXT;
    end else if (irq_timer) begin
      irq   = 1'b1;
      cause = CAUSE_IRQ_TMR;
    end else if (iaf)   cause = CAUSE_IAF;
    else if (ii)        cause = CAUSE_II;
    else if (iam)       cause = CAUSE_IAM;
    else if (ecall)     cause = priv_m ? CAUSE_ECALL_M : CAUSE_ECALL_U;
    else if (sam)       cause = CAUSE_SAM;
    else if (lam)       cause = CAUSE_LAM;
    else if (saf)       cause = CAUSE_SAF;
    else if (laf)       cause = CAUSE_LAF;
    else                take  = 1'b0;
  end

endmodule

// File: rtl/wb_trap_commit.sv
// Registered writeback/commit stage with a multi-cycle trap sequencer (MEPC, MCAUSE, MTVAL, redirect).
module wb_trap_commit
  import wb_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int REG_W    = 5,
  parameter int IRQ_SYNC = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WB_V,
  input  logic [XLEN-1:0]  WB_PC,
  input  logic [XLEN-1:0]  WB_NPC,
  input  logic [31:0]      WB_IR,
  input  logic [XLEN-1:0]  WB_ALU_RESULT,
  input  logic [XLEN-1:0]  WB_MEM_RESULT,
  input  logic [XLEN-1:0]  WB_RFD,
  input  logic [XLEN-1:0]  WB_CSRFD,
  input  logic [REG_W-1:0] WB_DRID,
  input  logic             MEM_PC_MUX,
  input  logic             WB_ECALL,
  input  logic             WB_MRET,
  input  logic             F_IAM,
  input  logic             F_IAF,
  input  logic             F_II,
  input  logic             MEM_LAM,
  input  logic             MEM_LAF,
  input  logic             MEM_SAM,
  input  logic             MEM_SAF,
  input  logic [XLEN-1:0]  WB_BADADDR,
  input  logic             TIMER,
  input  logic             EXTERNAL,
  input  logic             PRIVILEGE,
  input  logic             MSTATUS_MIE,
  input  logic [XLEN-1:0]  MTVEC,
  input  logic [XLEN-1:0]  MEPC,
  output logic [XLEN-1:0]  WB_RF_DATA,
  output logic [REG_W-1:0] WB_DRID_OUT,
  output logic             WB_LD_REG,
  output logic [XLEN-1:0]  WB_CSR_DATA,
  output logic             WB_ST_CSR,
  output logic             TRAP_CSR_WE,
  output logic [11:0]      TRAP_CSR_ADDR,
  output logic [XLEN-1:0]  TRAP_CSR_WDATA,
  output logic             WB_PC_MUX,
  output logic [XLEN-1:0]  WB_BR_JMP_TARGET,
  output logic             WB_FLUSH,
  output logic             WB_STALL,
  output logic             WB_RETIRE,
  output logic [XLEN-1:0]  WB_CAUSE,
  output logic             WB_CS
);

  trap_state_e      state, state_nxt;
  logic [IRQ_SYNC-1:0] tmr_sync, ext_sync;
  logic             take, irq;
  logic [3:0]       cause;
  logic             latch_trap;

  logic [XLEN-1:0]  trap_pc_p1, trap_tval_p1, trap_tvec_p1;
  logic             trap_irq_p1;
  logic [3:0]       trap_cause_p1;
  logic [XLEN-1:0]  mcause_p1, tvec_base_p1, tvec_target_p1;

  logic [XLEN-1:0]  rf_data_nxt, csr_data_nxt, csr_wdata_nxt, target_nxt, cause_nxt;
  logic [REG_W-1:0] drid_nxt;
  logic [11:0]      csr_addr_nxt;
  logic             ld_reg_nxt, st_csr_nxt, csr_we_nxt, pc_mux_nxt;
  logic             flush_nxt, stall_nxt, retire_nxt, cs_nxt, writes_rd;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmr_sync <= '0;
      ext_sync <= '0;
    end else begin
      tmr_sync[0] <= TIMER;
      ext_sync[0] <= EXTERNAL;
      for (int i = 1; i < IRQ_SYNC; i++) begin
        tmr_sync[i] <= tmr_sync[i-1];
        ext_sync[i] <= ext_sync[i-1];
      end
    end
  end

  trap_prio_enc u_prio (
    .irq_ext   (ext_sync[IRQ_SYNC-1] & MSTATUS_MIE),
    .irq_timer (tmr_sync[IRQ_SYNC-1] & MSTATUS_MIE),
    .iaf       (F_IAF),
    .ii        (F_II),
    .iam       (F_IAM),
    .ecall     (WB_ECALL),
    .priv_m    (PRIVILEGE),
    .sam       (MEM_SAM),
    .lam       (MEM_LAM),
    .saf       (MEM_SAF),
    .laf       (MEM_LAF),
    .take      (take),
    .irq       (irq),
    .cause     (cause)
  );

  // p1: trap context captured at detect, consumed by the following sequencer states
  always_ff @(posedge CLK) begin
    if (latch_trap) begin
      trap_pc_p1    <= WB_PC;
      trap_irq_p1   <= irq;
      trap_cause_p1 <= cause;
      trap_tvec_p1  <= MTVEC;
      if (irq)                     trap_tval_p1 <= '0;
      else if (tval_is_addr(cause)) trap_tval_p1 <= WB_BADADDR;
      else if (cause == CAUSE_II)   trap_tval_p1 <= XLEN'(WB_IR);
      else                          trap_tval_p1 <= '0;
    end
  end

  assign mcause_p1      = {trap_irq_p1, {(XLEN-5){1'b0}}, trap_cause_p1};
  assign tvec_base_p1   = {trap_tvec_p1[XLEN-1:2], 2'b00};
  assign tvec_target_p1 = (trap_irq_p1 && trap_tvec_p1[1:0] == 2'b01)
                        ? tvec_base_p1 + (XLEN'(trap_cause_p1) << 2) : tvec_base_p1;

  always_comb begin
    state_nxt     = state;
    latch_trap    = 1'b0;
    writes_rd     = 1'b0;
    rf_data_nxt   = '0;
    drid_nxt      = '0;
    ld_reg_nxt    = 1'b0;
    csr_data_nxt  = '0;
    st_csr_nxt    = 1'b0;
    csr_we_nxt    = 1'b0;
    csr_addr_nxt  = '0;
    csr_wdata_nxt = '0;
    pc_mux_nxt    = 1'b0;
    target_nxt    = '0;
    flush_nxt     = 1'b0;
    stall_nxt     = 1'b0;
    retire_nxt    = 1'b0;
    cause_nxt     = WB_CAUSE;
    cs_nxt        = 1'b0;
    case (state)
      S_IDLE: if (WB_V) begin
        if (take) begin
          state_nxt     = S_EPC;
          latch_trap    = 1'b1;
          stall_nxt     = 1'b1;
          csr_we_nxt    = 1'b1;
          csr_addr_nxt  = CSR_MEPC;
          csr_wdata_nxt = WB_PC;
        end else if (WB_MRET) begin
          pc_mux_nxt = 1'b1;
          target_nxt = MEPC;
          flush_nxt  = 1'b1;
          retire_nxt = 1'b1;
        end else begin
          case (WB_IR[6:0])
            OP_LOAD: begin
              rf_data_nxt = WB_MEM_RESULT;
              writes_rd   = 1'b1;
            end
            OP_IMM, OP_REG, OP_LUI, OP_AUIPC: begin
              rf_data_nxt = WB_ALU_RESULT;
              writes_rd   = 1'b1;
            end
            OP_SYSTEM: begin
              rf_data_nxt  = WB_RFD;
              csr_data_nxt = WB_CSRFD;
              st_csr_nxt   = 1'b1;
              writes_rd    = 1'b1;
            end
            OP_JALR, OP_JAL: begin
              rf_data_nxt = WB_NPC;
              writes_rd   = 1'b1;
            end
            default: writes_rd = 1'b0;
          endcase
          drid_nxt   = WB_DRID;
          ld_reg_nxt = writes_rd && (WB_DRID != '0);
          pc_mux_nxt = MEM_PC_MUX;
          target_nxt = WB_ALU_RESULT;
          retire_nxt = 1'b1;
        end
      end
      S_EPC: begin
        state_nxt     = S_CAUSE;
        stall_nxt     = 1'b1;
        csr_we_nxt    = 1'b1;
        csr_addr_nxt  = CSR_MCAUSE;
        csr_wdata_nxt = mcause_p1;
      end
      S_CAUSE: begin
        state_nxt     = S_TVAL;
        stall_nxt     = 1'b1;
        csr_we_nxt    = 1'b1;
        csr_addr_nxt  = CSR_MTVAL;
        csr_wdata_nxt = trap_tval_p1;
      end
      S_TVAL: begin
        state_nxt  = S_REDIRECT;
        stall_nxt  = 1'b1;
        pc_mux_nxt = 1'b1;
        target_nxt = tvec_target_p1;
        flush_nxt  = 1'b1;
        cs_nxt     = 1'b1;
        cause_nxt  = mcause_p1;
      end
      S_REDIRECT: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output stage: every output is the registered image of the values computed above
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state            <= S_IDLE;
      WB_RF_DATA       <= '0;
      WB_DRID_OUT      <= '0;
      WB_LD_REG        <= 1'b0;
      WB_CSR_DATA      <= '0;
      WB_ST_CSR        <= 1'b0;
      TRAP_CSR_WE      <= 1'b0;
      TRAP_CSR_ADDR    <= '0;
      TRAP_CSR_WDATA   <= '0;
      WB_PC_MUX        <= 1'b0;
      WB_BR_JMP_TARGET <= '0;
      WB_FLUSH         <= 1'b0;
      WB_STALL         <= 1'b0;
      WB_RETIRE        <= 1'b0;
      WB_CAUSE         <= '0;
      WB_CS            <= 1'b0;
    end else begin
      state            <= state_nxt;
      WB_RF_DATA       <= rf_data_nxt;
      WB_DRID_OUT      <= drid_nxt;
      WB_LD_REG        <= ld_reg_nxt;
      WB_CSR_DATA      <= csr_data_nxt;
      WB_ST_CSR        <= st_csr_nxt;
      TRAP_CSR_WE      <= csr_we_nxt;
      TRAP_CSR_ADDR    <= csr_addr_nxt;
      TRAP_CSR_WDATA   <= csr_wdata_nxt;
      WB_PC_MUX        <= pc_mux_nxt;
      WB_BR_JMP_TARGET <= target_nxt;
      WB_FLUSH         <= flush_nxt;
      WB_STALL         <= stall_nxt;
      WB_RETIRE        <= retire_nxt;
      WB_CAUSE         <= cause_nxt;
      WB_CS            <= cs_nxt;
    end
  end

endmodule

// File: tb/tb_wb_trap_commit.sv
// Directed bench for wb_trap_commit: a behavioural model predicts each output cycle, one process compares.
module tb_wb_trap_commit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_V, MEM_PC_MUX, WB_ECALL, WB_MRET, F_IAM, F_IAF, F_II;
  logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF, TIMER, EXTERNAL, PRIVILEGE, MSTATUS_MIE;
  logic [63:0] WB_PC, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_RFD, WB_CSRFD, WB_BADADDR, MTVEC, MEPC;
  logic [31:0] WB_IR;
  logic [4:0]  WB_DRID;
  logic [63:0] WB_RF_DATA, WB_CSR_DATA, TRAP_CSR_WDATA, WB_BR_JMP_TARGET, WB_CAUSE;
  logic [4:0]  WB_DRID_OUT;
  logic [11:0] TRAP_CSR_ADDR;
  logic        WB_LD_REG, WB_ST_CSR, TRAP_CSR_WE, WB_PC_MUX, WB_FLUSH, WB_STALL, WB_RETIRE, WB_CS;

  always #5 CLK = ~CLK;

  wb_trap_commit #(.XLEN(64), .REG_W(5), .IRQ_SYNC(2)) dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .WB_NPC(WB_NPC), .WB_IR(WB_IR),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_RFD(WB_RFD),
    .WB_CSRFD(WB_CSRFD), .WB_DRID(WB_DRID), .MEM_PC_MUX(MEM_PC_MUX), .WB_ECALL(WB_ECALL),
    .WB_MRET(WB_MRET), .F_IAM(F_IAM), .F_IAF(F_IAF), .F_II(F_II), .MEM_LAM(MEM_LAM),
    .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF), .WB_BADADDR(WB_BADADDR),
    .TIMER(TIMER), .EXTERNAL(EXTERNAL), .PRIVILEGE(PRIVILEGE), .MSTATUS_MIE(MSTATUS_MIE),
    .MTVEC(MTVEC), .MEPC(MEPC), .WB_RF_DATA(WB_RF_DATA), .WB_DRID_OUT(WB_DRID_OUT),
    .WB_LD_REG(WB_LD_REG), .WB_CSR_DATA(WB_CSR_DATA), .WB_ST_CSR(WB_ST_CSR),
    .TRAP_CSR_WE(TRAP_CSR_WE), .TRAP_CSR_ADDR(TRAP_CSR_ADDR), .TRAP_CSR_WDATA(TRAP_CSR_WDATA),
    .WB_PC_MUX(WB_PC_MUX), .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET), .WB_FLUSH(WB_FLUSH),
    .WB_STALL(WB_STALL), .WB_RETIRE(WB_RETIRE), .WB_CAUSE(WB_CAUSE), .WB_CS(WB_CS)
  );

  typedef struct packed {
    logic        wb_v;
    logic [63:0] pc, npc;
    logic [31:0] ir;
    logic [63:0] alu, mem, rfd, csrfd;
    logic [4:0]  drid;
    logic        mem_pc_mux, ecall, mret, iam, iaf, ii, lam, laf, sam, saf;
    logic [63:0] badaddr;
    logic        timer, ext, priv, mie;
    logic [63:0] mtvec, mepc;
  } in_t;

  typedef struct packed {
    logic [63:0] rf_data;
    logic [4:0]  drid_out;
    logic        ld_reg;
    logic [63:0] csr_data;
    logic        st_csr, csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic        pc_mux;
    logic [63:0] target;
    logic        flush, stall, retire;
    logic [63:0] cause;
    logic        cs;
  } out_t;

  int          n_vec = 0;
  int          n_miscmp = 0;
  logic [63:0] last_cause = '0;
  out_t        exp_q[$];
  out_t        exp_seq[5];
  int          exp_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t zero_out();
    out_t o;
    o = '0;
    o.cause = last_cause;
    return o;
  endfunction

  // Model: what the stage must show for each cycle following one WB instruction.
  task automatic model(input in_t v);
    out_t        o;
    logic        irq_p, take, wr;
    logic [3:0]  code;
    logic [63:0] tval, mcause, base, tgt;
    o = zero_out();
    exp_n = 1;
    exp_seq[0] = o;
    if (!v.wb_v) return;
    irq_p = (v.timer | v.ext) & v.mie;
    take = 1'b1;
    tval = '0;
    code = 4'd0;
    if (irq_p)      code = v.ext ? 4'd11 : 4'd7;
    else if (v.iaf) begin code = 4'd1; tval = v.badaddr; end
    else if (v.ii)  begin code = 4'd2; tval = {32'b0, v.ir}; end
    else if (v.iam) begin code = 4'd0; tval = v.badaddr; end
    else if (v.ecall) code = v.priv ? 4'd11 : 4'd8;
    else if (v.sam) begin code = 4'd6; tval = v.badaddr; end
    else if (v.lam) begin code = 4'd4; tval = v.badaddr; end
    else if (v.saf) begin code = 4'd7; tval = v.badaddr; end
    else if (v.laf) begin code = 4'd5; tval = v.badaddr; end
    else take = 1'b0;
    if (take) begin
      mcause = {irq_p, 59'b0, code};
      base = v.mtvec & ~64'h3;
      tgt = (irq_p && v.mtvec[1:0] == 2'b01) ? base + 64'(code) * 4 : base;
      o.stall = 1'b1; o.csr_we = 1'b1;
      o.csr_addr = 12'h341; o.csr_wdata = v.pc;   exp_seq[0] = o;
      o.csr_addr = 12'h342; o.csr_wdata = mcause; exp_seq[1] = o;
      o.csr_addr = 12'h343; o.csr_wdata = tval;   exp_seq[2] = o;
      last_cause = mcause;
      o = zero_out();
      o.stall = 1'b1; o.pc_mux = 1'b1; o.target = tgt; o.flush = 1'b1; o.cs = 1'b1;
      exp_seq[3] = o;
      exp_seq[4] = zero_out();
      exp_n = 5;
    end else if (v.mret) begin
      o.pc_mux = 1'b1; o.target = v.mepc; o.flush = 1'b1; o.retire = 1'b1;
      exp_seq[0] = o;
    end else begin
      wr = 1'b1;
      case (v.ir[6:0])
        7'h03:                      o.rf_data = v.mem;
        7'h13, 7'h33, 7'h37, 7'h17: o.rf_data = v.alu;
        7'h73: begin o.rf_data = v.rfd; o.csr_data = v.csrfd; o.st_csr = 1'b1; end
        7'h67, 7'h6f:               o.rf_data = v.npc;
        default:                    wr = 1'b0;
      endcase
      o.drid_out = v.drid;
      o.ld_reg = wr && (v.drid != 5'd0);
      o.retire = 1'b1;
      o.pc_mux = v.mem_pc_mux;
      o.target = v.alu;
      exp_seq[0] = o;
    end
  endtask

  task automatic drive(input in_t v);
    WB_V = v.wb_v; WB_PC = v.pc; WB_NPC = v.npc; WB_IR = v.ir;
    WB_ALU_RESULT = v.alu; WB_MEM_RESULT = v.mem; WB_RFD = v.rfd; WB_CSRFD = v.csrfd;
    WB_DRID = v.drid; MEM_PC_MUX = v.mem_pc_mux; WB_ECALL = v.ecall; WB_MRET = v.mret;
    F_IAM = v.iam; F_IAF = v.iaf; F_II = v.ii; MEM_LAM = v.lam; MEM_LAF = v.laf;
    MEM_SAM = v.sam; MEM_SAF = v.saf; WB_BADADDR = v.badaddr; TIMER = v.timer;
    EXTERNAL = v.ext; PRIVILEGE = v.priv; MSTATUS_MIE = v.mie; MTVEC = v.mtvec; MEPC = v.mepc;
  endtask

  task automatic cycle(input in_t v, input out_t e);
    drive(v);
    @(posedge CLK);
    #1;
    exp_q.push_back(e);
  endtask

  // Idle cycles first let the interrupt synchronisers settle; a trap keeps the
  // instruction on the inputs to show they are ignored during the sequence.
  task automatic run_vec(input in_t v);
    in_t idle;
    idle = v;
    idle.wb_v = 1'b0;
    for (int i = 0; i < 3; i++) cycle(idle, zero_out());
    model(v);
    for (int i = 0; i < exp_n; i++) cycle(v, exp_seq[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rf_data"}, WB_RF_DATA, 64'h0);
    check({tag, " ld_reg"}, {63'b0, WB_LD_REG}, 64'h0);
    check({tag, " csr_we"}, {63'b0, TRAP_CSR_WE}, 64'h0);
    check({tag, " csr_wdata"}, TRAP_CSR_WDATA, 64'h0);
    check({tag, " pc_mux"}, {63'b0, WB_PC_MUX}, 64'h0);
    check({tag, " stall"}, {63'b0, WB_STALL}, 64'h0);
    check({tag, " retire"}, {63'b0, WB_RETIRE}, 64'h0);
    check({tag, " cause"}, WB_CAUSE, 64'h0);
  endtask

  always @(negedge CLK) begin : compare
    out_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rf_data", WB_RF_DATA, e.rf_data);
      check("drid_out", {59'b0, WB_DRID_OUT}, {59'b0, e.drid_out});
      check("ld_reg", {63'b0, WB_LD_REG}, {63'b0, e.ld_reg});
      check("csr_data", WB_CSR_DATA, e.csr_data);
      check("st_csr", {63'b0, WB_ST_CSR}, {63'b0, e.st_csr});
      check("trap_we", {63'b0, TRAP_CSR_WE}, {63'b0, e.csr_we});
      check("trap_addr", {52'b0, TRAP_CSR_ADDR}, {52'b0, e.csr_addr});
      check("trap_wdata", TRAP_CSR_WDATA, e.csr_wdata);
      check("pc_mux", {63'b0, WB_PC_MUX}, {63'b0, e.pc_mux});
      check("target", WB_BR_JMP_TARGET, e.target);
      check("flush", {63'b0, WB_FLUSH}, {63'b0, e.flush});
      check("stall", {63'b0, WB_STALL}, {63'b0, e.stall});
      check("retire", {63'b0, WB_RETIRE}, {63'b0, e.retire});
      check("cause", WB_CAUSE, e.cause);
      check("cs", {63'b0, WB_CS}, {63'b0, e.cs});
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin : stim
    in_t v, idle;
    RESET = 1'b1;
    drive('0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // ADDI x5, x0, 10
    v = '0; v.wb_v = 1'b1; v.ir = 32'h00A00293; v.alu = 64'd10; v.drid = 5'd5;
    v.pc = 64'h100; v.npc = 64'h104;
    run_vec(v);
    check("pin addi rf", exp_seq[0].rf_data, 64'd10);
    check("pin addi ld", {63'b0, exp_seq[0].ld_reg}, 64'd1);
    v.drid = 5'd0;
    run_vec(v);
    check("pin x0 ld", {63'b0, exp_seq[0].ld_reg}, 64'd0);

    // Load, taken JAL, CSR read, store
    v = '0; v.wb_v = 1'b1; v.ir = 32'h0002B303; v.mem = 64'h1234_5678_9ABC_DEF0; v.drid = 5'd6;
    v.alu = 64'h40;
    run_vec(v);
    v = '0; v.wb_v = 1'b1; v.ir = 32'h008000EF; v.npc = 64'h204; v.alu = 64'h208;
    v.drid = 5'd1; v.mem_pc_mux = 1'b1;
    run_vec(v);
    check("pin jal rf", exp_seq[0].rf_data, 64'h204);
    v = '0; v.wb_v = 1'b1; v.ir = 32'h30002573; v.rfd = 64'h1800; v.csrfd = 64'h88; v.drid = 5'd10;
    run_vec(v);
    v = '0; v.wb_v = 1'b1; v.ir = 32'h00B52023; v.drid = 5'd3; v.alu = 64'h77;
    run_vec(v);

    // LAM + LAF together
    v = '0; v.wb_v = 1'b1; v.lam = 1'b1; v.laf = 1'b1; v.badaddr = 64'h1003; v.pc = 64'h80;
    v.mtvec = 64'h400; v.ir = 32'h0002B303; v.drid = 5'd6;
    run_vec(v);
    check("pin lam cause", exp_seq[1].csr_wdata, 64'h4);
    check("pin lam tval", exp_seq[2].csr_wdata, 64'h1003);
    check("pin lam target", exp_seq[3].target, 64'h400);

    // ECALL from U and M mode, vectored MTVEC does not apply to exceptions
    v = '0; v.wb_v = 1'b1; v.ecall = 1'b1; v.ir = 32'h00000073; v.pc = 64'h300;
    v.mtvec = 64'h401; v.badaddr = 64'hDEAD;
    run_vec(v);
    check("pin ecall-u", exp_seq[1].csr_wdata, 64'd8);
    v.priv = 1'b1;
    run_vec(v);
    check("pin ecall-m", exp_seq[1].csr_wdata, 64'd11);
    check("pin ecall tval", exp_seq[2].csr_wdata, 64'd0);

    // Interrupts: both lines, vectored
    v = '0; v.wb_v = 1'b1; v.timer = 1'b1; v.ext = 1'b1; v.mie = 1'b1; v.mtvec = 64'h1001;
    v.ir = 32'h00A00293; v.alu = 64'd10; v.drid = 5'd5; v.pc = 64'h500; v.iaf = 1'b1;
    run_vec(v);
    check("pin irq cause", exp_seq[1].csr_wdata, 64'h8000_0000_0000_000B);
    check("pin irq target", exp_seq[3].target, 64'h102C);
    v.ext = 1'b0; v.iaf = 1'b0; v.ii = 1'b1;
    run_vec(v);
    check("pin tmr target", exp_seq[3].target, 64'h101C);
    v.ext = 1'b1; v.ii = 1'b0; v.mie = 1'b0;
    run_vec(v);
    check("pin mie0 commit", {63'b0, exp_seq[0].retire}, 64'd1);

    // MRET alone, then MRET with a misaligned fetch
    v = '0; v.wb_v = 1'b1; v.mret = 1'b1; v.ir = 32'h30200073; v.mepc = 64'h200; v.mtvec = 64'h600;
    run_vec(v);
    check("pin mret target", exp_seq[0].target, 64'h200);
    v.iam = 1'b1; v.badaddr = 64'h202; v.pc = 64'h90;
    run_vec(v);

    // Exception ordering and MTVAL sources
    v = '0; v.wb_v = 1'b1; v.iaf = 1'b1; v.ii = 1'b1; v.iam = 1'b1; v.badaddr = 64'h7000;
    v.ir = 32'hFFFF_FFFF; v.mtvec = 64'h800;
    run_vec(v);
    v.iaf = 1'b0;
    run_vec(v);
    check("pin ii tval", exp_seq[2].csr_wdata, 64'h0000_0000_FFFF_FFFF);
    v = '0; v.wb_v = 1'b1; v.sam = 1'b1; v.lam = 1'b1; v.saf = 1'b1; v.badaddr = 64'h2001;
    v.mtvec = 64'h800;
    run_vec(v);
    v.sam = 1'b0; v.lam = 1'b0; v.laf = 1'b1;
    run_vec(v);
    v.saf = 1'b0; v.ecall = 1'b1; v.sam = 1'b1;
    run_vec(v);

    // Reset pulse in the middle of the sequence (MCAUSE write on the outputs)
    v = '0; v.wb_v = 1'b1; v.lam = 1'b1; v.badaddr = 64'h1003; v.pc = 64'h80; v.mtvec = 64'h400;
    idle = v; idle.wb_v = 1'b0;
    for (int i = 0; i < 3; i++) cycle(idle, zero_out());
    model(v);
    cycle(v, exp_seq[0]);
    cycle(idle, exp_seq[1]);
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    last_cause = '0;
    v = '0; v.wb_v = 1'b1; v.ir = 32'h00A00293; v.alu = 64'd10; v.drid = 5'd5;
    run_vec(v);

    @(negedge CLK);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miscmp++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
